// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between an issuing agent and alu_issue_ctrl.
// The controller sits on the slave side; the issuing agent uses the master side.
interface alu_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [31:0] rsp_rem;
    logic        rsp_err;

    modport master (
        output req_valid, req_op, req_src1, req_src2, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_rem, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_rem, rsp_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-issue sequencer for an external combinational ALU: latches one request,
// drives one-hot ALU control, waits out divider settling and holds the response.
module alu_issue_ctrl #(
    parameter int DIV_CYCLES = 4
) (
    input  logic               clk,
    input  logic               resetn,
    alu_issue_ctrl_if.slave    bus,
    output logic [14:0]        alu_control,
    output logic [31:0]        alu_src1,
    output logic [31:0]        alu_src2,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        div_odd,
    output logic [15:0]        ops_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_LAST  = 4'd13;
    // WAIT runs while the counter counts down to zero inclusive, hence the -1.
    localparam logic [3:0] DIV_LOAD = (DIV_CYCLES > 0) ? 4'(DIV_CYCLES - 1) : 4'd0;

    logic [1:0]  state_reg, state_next;
    logic [3:0]  op_reg;
    logic [31:0] src1_reg, src2_reg;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] result_reg, result_next;
    logic [31:0] rem_reg, rem_next;
    logic        err_reg, err_next;
    logic [15:0] ops_reg;

    logic [14:0] ctrl_map;
    logic        op_legal;
    logic        op_is_div;
    logic        div_by_zero;
    logic        accept;
    logic        handshake;

    // Bit 14 has no opcode; opcodes 14/15 match no decoder line and map to zero.
    for (genvar gi = 0; gi < 14; gi++) begin : g_dec
        assign ctrl_map[gi] = (op_reg == 4'(gi));
    end
    assign ctrl_map[14] = 1'b0;

    assign op_legal    = (op_reg <= OP_LAST);
    assign op_is_div   = (op_reg == OP_DIV);
    assign div_by_zero = (src2_reg == 32'd0);

    assign accept    = (state_reg == ST_IDLE) && bus.req_valid;
    assign handshake = (state_reg == ST_RESP) && bus.rsp_ready;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        rem_next    = rem_reg;
        err_next    = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!op_legal) begin
                    result_next = 32'd0;
                    rem_next    = 32'd0;
                    err_next    = 1'b1;
                    state_next  = ST_RESP;
                end else if (op_is_div && div_by_zero) begin
                    result_next = 32'hFFFF_FFFF;
                    rem_next    = src1_reg;
                    err_next    = 1'b1;
                    state_next  = ST_RESP;
                end else if (op_is_div && (DIV_CYCLES != 0)) begin
                    cnt_next   = DIV_LOAD;
                    state_next = ST_WAIT;
                end else if (op_is_div) begin
                    result_next = alu_result;
                    rem_next    = div_odd;
                    err_next    = 1'b0;
                    state_next  = ST_RESP;
                end else begin
                    result_next = alu_result;
                    rem_next    = 32'd0;
                    err_next    = 1'b0;
                    state_next  = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    result_next = alu_result;
                    rem_next    = div_odd;
                    err_next    = 1'b0;
                    state_next  = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= ST_IDLE;
            op_reg     <= 4'd0;
            src1_reg   <= 32'd0;
            src2_reg   <= 32'd0;
            cnt_reg    <= 4'd0;
            result_reg <= 32'd0;
            rem_reg    <= 32'd0;
            err_reg    <= 1'b0;
            ops_reg    <= 16'd0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            rem_reg    <= rem_next;
            err_reg    <= err_next;
            // Operands only move on accept so the ALU inputs stay put until then.
            if (accept) begin
                op_reg   <= bus.req_op;
                src1_reg <= bus.req_src1;
                src2_reg <= bus.req_src2;
            end
            if (handshake) begin
                ops_reg <= ops_reg + 16'd1;
            end
        end
    end

    assign alu_control = ((state_reg == ST_EXEC) || (state_reg == ST_WAIT)) ? ctrl_map : 15'd0;
    assign alu_src1    = src1_reg;
    assign alu_src2    = src2_reg;
    assign ops_done    = ops_reg;

    assign bus.req_ready  = (state_reg == ST_IDLE);
    assign bus.rsp_valid  = (state_reg == ST_RESP);
    assign bus.rsp_result = result_reg;
    assign bus.rsp_rem    = rem_reg;
    assign bus.rsp_err    = err_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed requests push expectations,
// a negedge monitor checks control, operands, latency, response and ops_done.
module tb_alu_issue_ctrl;

    localparam int DIV_CYCLES = 4;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] rem;
        logic        err;
        logic [14:0] ctrl;
        int          lat;
        int          stall;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic [14:0] alu_control;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] alu_result;
    logic [31:0] div_odd;
    logic [15:0] ops_done;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          quiet = 0;
    logic [15:0] ops_exp = 16'd0;
    exp_t        exp_q[$];

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .alu_control(alu_control),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_result (alu_result),
        .div_odd    (div_odd),
        .ops_done   (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU standing in for the real datapath.
    always_comb begin
        alu_result = 32'd0;
        div_odd    = 32'd0;
        case (alu_control)
            15'h0001: alu_result = alu_src1 + alu_src2;
            15'h0002: alu_result = alu_src1 - alu_src2;
            15'h0004: alu_result = alu_src1 * alu_src2;
            15'h0008: begin
                if (alu_src2 != 32'd0) begin
                    alu_result = alu_src1 / alu_src2;
                    div_odd    = alu_src1 % alu_src2;
                end
            end
            15'h0010: alu_result = ($signed(alu_src1) < $signed(alu_src2)) ? 32'd1 : 32'd0;
            15'h0020: alu_result = (alu_src1 < alu_src2) ? 32'd1 : 32'd0;
            15'h0040: alu_result = alu_src1 & alu_src2;
            15'h0080: alu_result = ~(alu_src1 | alu_src2);
            15'h0100: alu_result = alu_src1 | alu_src2;
            15'h0200: alu_result = alu_src1 ^ alu_src2;
            15'h0400: alu_result = alu_src2 << alu_src1[4:0];
            15'h0800: alu_result = alu_src2 >> alu_src1[4:0];
            15'h1000: alu_result = $unsigned($signed(alu_src2) >>> alu_src1[4:0]);
            15'h2000: alu_result = {alu_src2[15:0], 16'h0000};
            default:  alu_result = 32'd0;
        endcase
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // Response sink: throttles rsp_ready by the stall count of the head expectation.
    initial begin : sink
        int  stall;
        bit  in_resp;
        stall         = 0;
        in_resp       = 0;
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (bus.rsp_valid) begin
                if (!in_resp) begin
                    in_resp = 1;
                    stall   = (exp_q.size() > 0) ? exp_q[0].stall : 0;
                end
                if (stall > 0) begin
                    bus.rsp_ready = 1'b0;
                    stall--;
                end else begin
                    bus.rsp_ready = 1'b1;
                end
            end else begin
                in_resp       = 0;
                bus.rsp_ready = 1'b1;
            end
        end
    end

    // Monitor: owns the pop side of the scoreboard.
    initial begin : monitor
        exp_t        cur;
        int          acc_cyc;
        bit          busy;
        bit          seen;
        logic [31:0] h_res;
        logic [31:0] h_rem;
        logic        h_err;
        acc_cyc = 0;
        busy    = 0;
        seen    = 0;
        h_res   = 32'd0;
        h_rem   = 32'd0;
        h_err   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn) begin
                exp_q.delete();
                busy    = 0;
                seen    = 0;
                ops_exp = 16'd0;
            end else begin
                check("ops_done", 32'(ops_done), 32'(ops_exp));
                if (bus.rsp_valid) begin
                    check("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
                    check("alu_control_in_resp", 32'(alu_control), 32'd0);
                    if (!busy) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1, expected 0");
                    end else if (!seen) begin
                        seen  = 1;
                        check("latency", 32'(cyc - acc_cyc), 32'(cur.lat));
                        check("rsp_result", bus.rsp_result, cur.res);
                        check("rsp_rem", bus.rsp_rem, cur.rem);
                        check("rsp_err", 32'(bus.rsp_err), 32'(cur.err));
                        h_res = bus.rsp_result;
                        h_rem = bus.rsp_rem;
                        h_err = bus.rsp_err;
                    end else begin
                        check("hold_result", bus.rsp_result, h_res);
                        check("hold_rem", bus.rsp_rem, h_rem);
                        check("hold_err", 32'(bus.rsp_err), 32'(h_err));
                    end
                    if (bus.rsp_ready && busy) begin
                        if (!quiet)
                            $display("rsp op=%0d src1=0x%08h src2=0x%08h result=0x%08h rem=0x%08h err=%0d ops_done=%0d",
                                     cur.op, cur.a, cur.b, bus.rsp_result, bus.rsp_rem, bus.rsp_err, ops_done);
                        void'(exp_q.pop_front());
                        ops_exp = ops_exp + 16'd1;
                        busy    = 0;
                        seen    = 0;
                    end
                end else if (busy) begin
                    check("alu_control", 32'(alu_control), 32'(cur.ctrl));
                    check("alu_src1", alu_src1, cur.a);
                    check("alu_src2", alu_src2, cur.b);
                end
                if (bus.req_valid && bus.req_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_accept: got accept, expected none");
                    end else begin
                        cur     = exp_q[0];
                        busy    = 1;
                        acc_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL rsp_timeout: got %0d pending, expected 0", exp_q.size());
                exp_q.delete();
                break;
            end
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [31:0] rem, input logic err,
                         input int stall, input bit wait_done);
        exp_t e;
        int   n;
        e.op    = op;
        e.a     = a;
        e.b     = b;
        e.res   = res;
        e.rem   = rem;
        e.err   = err;
        e.ctrl  = (op <= 4'd13) ? (15'd1 << op) : 15'd0;
        e.lat   = (op == 4'd3 && b != 32'd0) ? 2 + DIV_CYCLES : 2;
        e.stall = stall;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.req_op    = op;
        bus.req_src1  = a;
        bus.req_src2  = b;
        bus.req_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got req_ready=0, expected 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (wait_done) wait_idle();
    endtask

    initial begin : watchdog
        #4000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
        bus.req_src1  = 32'd0;
        bus.req_src2  = 32'd0;
        resetn        = 1'b1;
        #1 resetn     = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_alu_control", 32'(alu_control), 32'd0);
        check("rst_alu_src1", alu_src1, 32'd0);
        check("rst_alu_src2", alu_src2, 32'd0);
        check("rst_rsp_result", bus.rsp_result, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_ops_done", 32'(ops_done), 32'd0);

        //     op     src1          src2          result        rem    err  stall wait
        issue(4'd0,  32'd5,        32'd7,        32'd12,       32'd0, 1'b0, 0, 1);
        issue(4'd3,  32'd100,      32'd7,        32'd14,       32'd2, 1'b0, 0, 1);
        // Next request is raised while the stalled sub is still in flight.
        issue(4'd1,  32'd3,        32'd5,        32'hFFFFFFFE, 32'd0, 1'b0, 3, 0);
        issue(4'd0,  32'd1,        32'd2,        32'd3,        32'd0, 1'b0, 0, 1);
        issue(4'd15, 32'd1,        32'd2,        32'd0,        32'd0, 1'b1, 0, 1);
        issue(4'd14, 32'd4,        32'd4,        32'd0,        32'd0, 1'b1, 0, 1);
        issue(4'd3,  32'd9,        32'd0,        32'hFFFFFFFF, 32'd9, 1'b1, 0, 1);
        issue(4'd2,  32'd6,        32'd7,        32'd42,       32'd0, 1'b0, 0, 1);
        issue(4'd4,  32'hFFFFFFFF, 32'd1,        32'd1,        32'd0, 1'b0, 0, 1);
        issue(4'd5,  32'hFFFFFFFF, 32'd1,        32'd0,        32'd0, 1'b0, 0, 1);
        issue(4'd6,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'd0, 1'b0, 0, 1);
        issue(4'd7,  32'h0F0F0000, 32'h00000F0F, 32'hF0F0F0F0, 32'd0, 1'b0, 0, 1);
        issue(4'd8,  32'h12340000, 32'h00005678, 32'h12345678, 32'd0, 1'b0, 0, 1);
        issue(4'd9,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 32'd0, 1'b0, 0, 1);
        issue(4'd10, 32'd4,        32'd1,        32'd16,       32'd0, 1'b0, 0, 1);
        issue(4'd11, 32'd8,        32'h80000000, 32'h00800000, 32'd0, 1'b0, 0, 1);
        issue(4'd12, 32'd8,        32'h80000000, 32'hFF800000, 32'd0, 1'b0, 0, 1);
        issue(4'd13, 32'd0,        32'h0000ABCD, 32'hABCD0000, 32'd0, 1'b0, 0, 1);
        issue(4'd3,  32'd17,       32'd5,        32'd3,        32'd2, 1'b0, 1, 1);

        // Reset in the middle of a divide's WAIT phase.
        issue(4'd3, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        $display("reset asserted during divide wait");
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_alu_control", 32'(alu_control), 32'd0);
        check("mid_rst_alu_src1", alu_src1, 32'd0);
        check("mid_rst_alu_src2", alu_src2, 32'd0);
        check("mid_rst_rsp_result", bus.rsp_result, 32'd0);
        check("mid_rst_rsp_rem", bus.rsp_rem, 32'd0);
        check("mid_rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("mid_rst_ops_done", 32'(ops_done), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end
        check("post_rst_ops_done", 32'(ops_done), 32'd0);

        // Walk ops_done up to its top value, then one more handshake wraps it.
        quiet = 1;
        for (int i = 0; i < 70000 && ops_exp != 16'hFFFF; i++) begin
            issue(4'd0, 32'(i), 32'd1, 32'(i) + 32'd1, 32'd0, 1'b0, 0, 1);
        end
        @(negedge clk);
        #1;
        check("ops_done_full", 32'(ops_done), 32'h0000FFFF);
        quiet = 0;
        issue(4'd0, 32'd40, 32'd2, 32'd42, 32'd0, 1'b0, 0, 1);
        @(negedge clk);
        #1;
        check("ops_done_wrap", 32'(ops_done), 32'h00000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_CYCLES, default 4, meaning extra settle cycles granted to the combinational divider before its result is captured (range 0..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  operation request present.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_op  input  4  operation code: 0 add, 1 sub, 2 mul, 3 div, 4 slt, 5 sltu, 6 and, 7 nor, 8 or, 9 xor, 10 sll, 11 srl, 12 sra, 13 lui, 14-15 illegal.
REQ-007 req_src1 / req_src2  input  32 each  operands (src1 = shift amount for shifts).
REQ-008 alu_control  output  15  one-hot ALU control to the ALU.
REQ-009 alu_src1 / alu_src2  output  32 each  operands to the ALU.
REQ-010 alu_result  input  32  ALU result.
REQ-011 div_odd  input  32  ALU remainder (zero when not dividing).
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_result / rsp_rem  output  32 each  captured result / remainder.
REQ-015 rsp_err  output  1  illegal opcode or divide-by-zero.
REQ-016 ops_done  output  16  count of completed response handshakes.

Function
REQ-017 The block SHALL implement FSM states IDLE, EXEC, WAIT, RESP; req_ready=1 only in IDLE, rsp_valid=1 only in RESP.
REQ-018 IDLE: on req_valid=1 the block SHALL register op, src1, src2 and go to EXEC; otherwise stay.
REQ-019 Opcode n (0..13) SHALL map to alu_control = 1<<n; bit 14 SHALL never be set; illegal opcodes SHALL map to 0.
REQ-020 alu_control SHALL equal the mapped value in EXEC and WAIT and SHALL be 0 in IDLE and RESP.
REQ-021 alu_src1/alu_src2 SHALL present the registered operands, stable from EXEC until the next accept.
REQ-022 EXEC, non-div legal op: capture alu_result into rsp_result, 0 into rsp_rem, rsp_err=0, go to RESP.
REQ-023 EXEC, div with src2!=0: if DIV_CYCLES=0 capture alu_result/div_odd and go to RESP; else load counter with DIV_CYCLES-1 and go to WAIT.
REQ-024 WAIT: decrement counter each cycle; at counter 0 capture alu_result into rsp_result and div_odd into rsp_rem, go to RESP.
REQ-025 Div with src2=0: EXEC SHALL skip WAIT, set rsp_result=0xFFFFFFFF, rsp_rem=src1, rsp_err=1, go to RESP.
REQ-026 Illegal opcode: EXEC SHALL set rsp_result=0, rsp_rem=0, rsp_err=1, go to RESP.
REQ-027 Latency: request accepted at edge T SHALL give rsp_valid=1 after edge T+2 (non-div, illegal, div-by-zero) or T+2+DIV_CYCLES (div).
REQ-028 RESP: rsp_valid and rsp_* SHALL hold stable until rsp_ready=1; on handshake go to IDLE and increment ops_done.
REQ-029 ops_done SHALL wrap 0xFFFF -> 0x0000; error responses SHALL count.
REQ-030 A request presented in the same cycle as a response handshake SHALL NOT be accepted (req_ready=0 in RESP); it is accepted in the following IDLE cycle.

Reset
REQ-031 resetn=0 SHALL asynchronously force state IDLE, counter 0, ops_done 0, alu_control 0, alu_src1/2 0, rsp_result/rsp_rem 0, rsp_err 0, rsp_valid 0, req_ready 1 after release.
REQ-032 Reset in any state, including mid-WAIT, SHALL abandon the operation with no response and no ops_done increment.

Verification
REQ-033 op=0, src1=5, src2=7, rsp_ready=1 -> alu_control=0x0001 in EXEC, rsp_result=12, rsp_err=0, rsp_valid two cycles after accept.
REQ-034 op=3, src1=100, src2=7, DIV_CYCLES=4 -> alu_control=0x0008 for 5 cycles, rsp_result=14, rsp_rem=2, rsp_valid six cycles after accept.
REQ-035 op=1, src1=3, src2=5, rsp_ready low 3 cycles -> rsp_result=0xFFFFFFFE held stable 3 cycles, req_ready=0 throughout, ops_done +1 only on handshake.
REQ-036 op=15 -> rsp_err=1, rsp_result=0, alu_control=0; op=3 with src2=0, src1=9 -> rsp_err=1, rsp_result=0xFFFFFFFF, rsp_rem=9, no WAIT cycles.
REQ-037 Assert resetn=0 during WAIT of a div -> all outputs at reset values immediately, no response after release, ops_done=0.
REQ-038 Preload ops_done to 0xFFFF via 65535 add handshakes, one more handshake -> ops_done=0x0000.
